// File: rtl/sfp_port_supervisor_if.sv
// Board-side bundle of the SFP supervisor: per-port enables, raw link/activity in, pin and LED drives out.
// link_drops exists only when SFP_SUPERVISOR_STATS_EN is defined.
interface sfp_port_supervisor_if #(
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0] port_en;
    logic [NUM_PORTS-1:0] link_up;
    logic [NUM_PORTS-1:0] activity;
    logic [NUM_PORTS-1:0] tx_disable;
    logic [NUM_PORTS-1:0] link_stable;
    logic [NUM_PORTS-1:0] led;
`ifdef SFP_SUPERVISOR_STATS_EN
    logic [16*NUM_PORTS-1:0] link_drops;

    modport master (
        output port_en, link_up, activity,
        input  tx_disable, link_stable, led, link_drops
    );
    modport slave (
        input  port_en, link_up, activity,
        output tx_disable, link_stable, led, link_drops
    );
`else
    modport master (
        output port_en, link_up, activity,
        input  tx_disable, link_stable, led
    );
    modport slave (
        input  port_en, link_up, activity,
        output tx_disable, link_stable, led
    );
`endif
endinterface

// File: rtl/sfp_port_supervisor.sv
// Per-port SFP+ supervisor: TX_DISABLE sequencing, link debounce and retry, status LEDs; outputs registered (1 cycle), no backpressure.
// Optional per-port link-drop counters when SFP_SUPERVISOR_STATS_EN is defined.
module sfp_port_supervisor #(
    parameter int NUM_PORTS      = 4,
    parameter int TICK_DIV       = 156250,
    parameter int SETTLE_TICKS   = 10,
    parameter int DEBOUNCE_TICKS = 5,
    parameter int LINK_TIMEOUT   = 2000,
    parameter int OFF_TICKS      = 100,
    parameter int BLINK_TICKS    = 250,
    parameter int ACT_TICKS      = 30
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    sfp_port_supervisor_if.slave bus
);

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_WAIT     = 2'd2,
        ST_LINKED   = 2'd3
    } state_t;

    localparam int TMAX_A = (LINK_TIMEOUT > SETTLE_TICKS) ? LINK_TIMEOUT : SETTLE_TICKS;
    localparam int TMAX   = (TMAX_A > OFF_TICKS) ? TMAX_A : OFF_TICKS;
    localparam int PW     = $clog2(TICK_DIV);
    localparam int TW     = $clog2(TMAX + 1);
    localparam int DW     = $clog2(DEBOUNCE_TICKS + 1);
    localparam int BW     = $clog2(BLINK_TICKS + 1);
    localparam int AW     = $clog2(ACT_TICKS + 1);

    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TMAX_T     = TW'(TMAX);
    localparam logic [TW-1:0] OFF_T      = TW'(OFF_TICKS);
    localparam logic [TW-1:0] SETTLE_T   = TW'(SETTLE_TICKS);
    localparam logic [TW-1:0] TIMEOUT_T  = TW'(LINK_TIMEOUT);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
    localparam logic [AW-1:0] ACT_LOAD   = AW'(ACT_TICKS);

    logic [PW-1:0]        pre_cnt;
    logic                 tick;
    logic [BW-1:0]        blink_cnt;
    logic                 blink;
    logic [NUM_PORTS-1:0] sync1, sync2, link_db;
    logic [DW-1:0]        db_cnt  [NUM_PORTS];
    logic [AW-1:0]        act_cnt [NUM_PORTS];
    logic [TW-1:0]        timer   [NUM_PORTS];
    state_t               state_q [NUM_PORTS];
    state_t               state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] tx_dis_c, stable_c, led_c;
    logic [NUM_PORTS-1:0] tx_dis_q, stable_q, led_q;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pre_cnt   <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Debounce counts ticks that disagree with the current debounced value.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync1   <= '0;
            sync2   <= '0;
            link_db <= '0;
            for (int p = 0; p < NUM_PORTS; p++) db_cnt[p] <= '0;
        end else begin
            sync1 <= bus.link_up;
            sync2 <= sync1;
            if (tick) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (sync2[p] == link_db[p]) begin
                        db_cnt[p] <= '0;
                    end else if (db_cnt[p] == DEB_LAST) begin
                        link_db[p] <= sync2[p];
                        db_cnt[p]  <= '0;
                    end else begin
                        db_cnt[p] <= db_cnt[p] + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < NUM_PORTS; p++) act_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.activity[p])
                    act_cnt[p] <= ACT_LOAD;
                else if (tick && act_cnt[p] != '0)
                    act_cnt[p] <= act_cnt[p] - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= ST_DISABLED;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) state_q[p] <= state_d[p];
        end
    end

    // Port disable outranks everything; a link rising on the timeout tick still wins.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            if (!bus.port_en[p]) begin
                state_d[p] = ST_DISABLED;
            end else begin
                case (state_q[p])
                    ST_DISABLED: if (timer[p] >= OFF_T) state_d[p] = ST_SETTLE;
                    ST_SETTLE:   if (timer[p] == SETTLE_T) state_d[p] = ST_WAIT;
                    ST_WAIT: begin
                        if (link_db[p])
                            state_d[p] = ST_LINKED;
                        else if (timer[p] == TIMEOUT_T)
                            state_d[p] = ST_DISABLED;
                    end
                    ST_LINKED:   if (!link_db[p]) state_d[p] = ST_WAIT;
                    default:     state_d[p] = ST_DISABLED;
                endcase
            end
        end
    end

    always_comb begin
        tx_dis_c = '0;
        stable_c = '0;
        led_c    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            case (state_q[p])
                ST_SETTLE, ST_WAIT: led_c[p] = blink;
                ST_LINKED: begin
                    stable_c[p] = 1'b1;
                    led_c[p]    = (act_cnt[p] == '0);
                end
                default: tx_dis_c[p] = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_dis_q <= '1;
            stable_q <= '0;
            led_q    <= '0;
            for (int p = 0; p < NUM_PORTS; p++) timer[p] <= '0;
        end else begin
            tx_dis_q <= tx_dis_c;
            stable_q <= stable_c;
            led_q    <= led_c;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (state_d[p] != state_q[p])
                    timer[p] <= '0;
                else if (tick && timer[p] != TMAX_T)
                    timer[p] <= timer[p] + 1'b1;
            end
        end
    end

    assign bus.tx_disable  = tx_dis_q;
    assign bus.link_stable = stable_q;
    assign bus.led         = led_q;

`ifdef SFP_SUPERVISOR_STATS_EN
    logic [15:0] drops [NUM_PORTS];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int p = 0; p < NUM_PORTS; p++) drops[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (state_q[p] == ST_LINKED && state_d[p] == ST_WAIT && drops[p] != 16'hFFFF)
                    drops[p] <= drops[p] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_drops
        assign bus.link_drops[16*g +: 16] = drops[g];
    end
`endif

endmodule

// File: tb/tb_sfp_port_supervisor.sv
// Directed bench for sfp_port_supervisor with a small configuration (2 ports, 4-cycle tick).
module tb_sfp_port_supervisor;

    logic i_clk = 1'b0;
    logic i_reset;
    int   checks = 0;
    int   errors = 0;
    int   pidx   = -1;   // index of the last posedge since reset release

    always #5 i_clk = ~i_clk;

    sfp_port_supervisor_if #(.NUM_PORTS(2)) sif ();

    sfp_port_supervisor #(
        .NUM_PORTS(2), .TICK_DIV(4), .SETTLE_TICKS(3), .DEBOUNCE_TICKS(2),
        .LINK_TIMEOUT(8), .OFF_TICKS(2), .BLINK_TICKS(2), .ACT_TICKS(3)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (sif)
    );

    task automatic do_reset(input logic [1:0] en, input logic [1:0] link);
        i_reset      = 1'b1;
        sif.port_en  = en;
        sif.link_up  = link;
        sif.activity = 2'b00;
        repeat (5) @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        pidx    = -1;
    endtask

    task automatic adv(input int n);
        while (pidx < n) begin
            @(posedge i_clk);
            pidx++;
        end
        #1;
    endtask

    task automatic test_reset;
        do_reset(2'b00, 2'b00);
        checks++;
        if ({sif.tx_disable, sif.link_stable, sif.led} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_vals got tx=%b st=%b led=%b exp tx=11 st=00 led=00", sif.tx_disable, sif.link_stable, sif.led);
        end
`ifdef SFP_SUPERVISOR_STATS_EN
        checks++;
        if (sif.link_drops !== 32'h0) begin
            errors++;
            $display("FAIL reset_drops got %h exp 0", sif.link_drops);
        end
`endif
        for (int i = 0; i < 200; i++) begin
            adv(i);
            checks++;
            if ({sif.tx_disable, sif.link_stable, sif.led} !== 6'b110000) begin
                errors++;
                $display("FAIL idle_c%0d got tx=%b st=%b led=%b exp tx=11 st=00 led=00", i, sif.tx_disable, sif.link_stable, sif.led);
            end
        end
    endtask

    task automatic test_link_up;
        do_reset(2'b01, 2'b01);
        adv(8);
        checks++;
        if (sif.tx_disable !== 2'b11) begin
            errors++;
            $display("FAIL bringup_off_p8 got %b exp 11", sif.tx_disable);
        end
        adv(9);
        checks++;
        if (sif.tx_disable !== 2'b10) begin
            errors++;
            $display("FAIL bringup_on_p9 got %b exp 10", sif.tx_disable);
        end
        adv(21);
        checks++;
        if (sif.link_stable !== 2'b00) begin
            errors++;
            $display("FAIL bringup_stable_p21 got %b exp 00", sif.link_stable);
        end
        adv(22);
        checks++;
        if ({sif.link_stable, sif.led, sif.tx_disable} !== 6'b010110) begin
            errors++;
            $display("FAIL bringup_linked_p22 got st=%b led=%b tx=%b exp st=01 led=01 tx=10", sif.link_stable, sif.led, sif.tx_disable);
        end
    endtask

    task automatic test_debounce;
        adv(24);
        sif.link_up = 2'b00;
        adv(28);
        sif.link_up = 2'b01;
        adv(40);
        checks++;
        if (sif.link_stable !== 2'b01) begin
            errors++;
            $display("FAIL glitch_ignored got %b exp 01", sif.link_stable);
        end
        sif.link_up = 2'b00;
`ifdef SFP_SUPERVISOR_STATS_EN
        adv(47);
        checks++;
        if (sif.link_drops !== 32'h0) begin
            errors++;
            $display("FAIL drops_before got %h exp 0", sif.link_drops);
        end
`endif
        adv(48);
        checks++;
        if (sif.link_stable !== 2'b01) begin
            errors++;
            $display("FAIL drop_stable_p48 got %b exp 01", sif.link_stable);
        end
`ifdef SFP_SUPERVISOR_STATS_EN
        checks++;
        if (sif.link_drops !== 32'h0000_0001) begin
            errors++;
            $display("FAIL drops_after got %h exp 00000001", sif.link_drops);
        end
`endif
        adv(49);
        checks++;
        if ({sif.link_stable, sif.tx_disable} !== 4'b0010) begin
            errors++;
            $display("FAIL drop_wait_p49 got st=%b tx=%b exp st=00 tx=10", sif.link_stable, sif.tx_disable);
        end
        adv(55);
        checks++;
        if (sif.led[0] !== 1'b0) begin
            errors++;
            $display("FAIL blink_p55 got %b exp 0", sif.led[0]);
        end
        adv(56);
        checks++;
        if (sif.led[0] !== 1'b1) begin
            errors++;
            $display("FAIL blink_p56 got %b exp 1", sif.led[0]);
        end
        adv(63);
        checks++;
        if (sif.led[0] !== 1'b1) begin
            errors++;
            $display("FAIL blink_p63 got %b exp 1", sif.led[0]);
        end
        adv(64);
        checks++;
        if (sif.led[0] !== 1'b0) begin
            errors++;
            $display("FAIL blink_p64 got %b exp 0", sif.led[0]);
        end
        sif.link_up = 2'b01;
        adv(72);
        checks++;
        if (sif.link_stable !== 2'b00) begin
            errors++;
            $display("FAIL relink_p72 got %b exp 00", sif.link_stable);
        end
        adv(73);
        checks++;
        if ({sif.link_stable, sif.led} !== 4'b0101) begin
            errors++;
            $display("FAIL relink_p73 got st=%b led=%b exp st=01 led=01", sif.link_stable, sif.led);
        end
    endtask

    task automatic test_activity;
        adv(80);
        sif.activity = 2'b01;
        adv(81);
        sif.activity = 2'b00;
        checks++;
        if (sif.led !== 2'b01) begin
            errors++;
            $display("FAIL act_p81 got %b exp 01", sif.led);
        end
        adv(82);
        checks++;
        if (sif.led !== 2'b00) begin
            errors++;
            $display("FAIL act_p82 got %b exp 00", sif.led);
        end
        adv(91);
        checks++;
        if (sif.led !== 2'b00) begin
            errors++;
            $display("FAIL act_p91 got %b exp 00", sif.led);
        end
        adv(92);
        checks++;
        if (sif.led !== 2'b01) begin
            errors++;
            $display("FAIL act_p92 got %b exp 01", sif.led);
        end
        for (int m = 0; m < 10; m++) begin
            adv(95 + 4*m);
            sif.activity = 2'b01;
            adv(96 + 4*m);
            sif.activity = 2'b00;
            adv(98 + 4*m);
            checks++;
            if (sif.led !== 2'b00) begin
                errors++;
                $display("FAIL act_train_%0d got %b exp 00", m, sif.led);
            end
        end
        adv(143);
        checks++;
        if (sif.led !== 2'b00) begin
            errors++;
            $display("FAIL act_tail_p143 got %b exp 00", sif.led);
        end
        adv(144);
        checks++;
        if (sif.led !== 2'b01) begin
            errors++;
            $display("FAIL act_tail_p144 got %b exp 01", sif.led);
        end
    endtask

    task automatic test_port_disable;
        adv(150);
        sif.port_en = 2'b00;
        adv(151);
        checks++;
        if ({sif.tx_disable, sif.link_stable} !== 4'b1001) begin
            errors++;
            $display("FAIL dis_p151 got tx=%b st=%b exp tx=10 st=01", sif.tx_disable, sif.link_stable);
        end
        adv(152);
        checks++;
        if ({sif.tx_disable, sif.link_stable, sif.led} !== 6'b110000) begin
            errors++;
            $display("FAIL dis_p152 got tx=%b st=%b led=%b exp tx=11 st=00 led=00", sif.tx_disable, sif.link_stable, sif.led);
        end
`ifdef SFP_SUPERVISOR_STATS_EN
        checks++;
        if (sif.link_drops !== 32'h0000_0001) begin
            errors++;
            $display("FAIL dis_drops got %h exp 00000001", sif.link_drops);
        end
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        checks++;
        if (sif.link_drops !== 32'h0) begin
            errors++;
            $display("FAIL drops_cleared got %h exp 0", sif.link_drops);
        end
`endif
    endtask

    task automatic test_retry;
        do_reset(2'b10, 2'b00);
        adv(52);
        checks++;
        if (sif.tx_disable !== 2'b01) begin
            errors++;
            $display("FAIL retry_p52 got %b exp 01", sif.tx_disable);
        end
        adv(53);
        checks++;
        if (sif.tx_disable !== 2'b11) begin
            errors++;
            $display("FAIL retry_p53 got %b exp 11", sif.tx_disable);
        end
        adv(60);
        checks++;
        if (sif.tx_disable !== 2'b11) begin
            errors++;
            $display("FAIL retry_p60 got %b exp 11", sif.tx_disable);
        end
        adv(61);
        checks++;
        if (sif.tx_disable !== 2'b01) begin
            errors++;
            $display("FAIL retry_p61 got %b exp 01", sif.tx_disable);
        end
        adv(104);
        checks++;
        if (sif.tx_disable !== 2'b01) begin
            errors++;
            $display("FAIL retry_p104 got %b exp 01", sif.tx_disable);
        end
        adv(105);
        checks++;
        if (sif.tx_disable !== 2'b11) begin
            errors++;
            $display("FAIL retry_p105 got %b exp 11", sif.tx_disable);
        end
        adv(112);
        checks++;
        if (sif.tx_disable !== 2'b11) begin
            errors++;
            $display("FAIL retry_p112 got %b exp 11", sif.tx_disable);
        end
        adv(113);
        checks++;
        if ({sif.tx_disable, sif.link_stable, sif.led[0]} !== 5'b01000) begin
            errors++;
            $display("FAIL retry_p113 got tx=%b st=%b led0=%b exp tx=01 st=00 led0=0", sif.tx_disable, sif.link_stable, sif.led[0]);
        end
    endtask

    task automatic test_mid_reset;
        do_reset(2'b11, 2'b01);
        adv(30);
        checks++;
        if ({sif.tx_disable, sif.link_stable, sif.led[0]} !== 5'b00011) begin
            errors++;
            $display("FAIL midrst_pre got tx=%b st=%b led0=%b exp tx=00 st=01 led0=1", sif.tx_disable, sif.link_stable, sif.led[0]);
        end
        i_reset = 1'b1;
        adv(31);
        checks++;
        if ({sif.tx_disable, sif.link_stable, sif.led} !== 6'b110000) begin
            errors++;
            $display("FAIL midrst_post got tx=%b st=%b led=%b exp tx=11 st=00 led=00", sif.tx_disable, sif.link_stable, sif.led);
        end
        i_reset = 1'b0;
    endtask

    initial begin
        i_reset      = 1'b1;
        sif.port_en  = 2'b00;
        sif.link_up  = 2'b00;
        sif.activity = 2'b00;
        test_reset();
        test_link_up();
        test_debounce();
        test_activity();
        test_port_disable();
        test_retry();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
